// File: rtl/hp_damage_unit_if.sv
// rtl/hp_damage_unit_if.sv - request, stat and status bundle between battle FSM and damage unit
interface hp_damage_unit_if #(
  parameter int HP_W  = 8,
  parameter int ATK_W = 4
);
  logic             load_ai_hp;
  logic [HP_W-1:0]  ai_hp_in;
  logic             apply_p_damage;
  logic             apply_ai_damage;
  logic             active_trainer;
  logic             target;
  logic [ATK_W-1:0] p_atk;
  logic [ATK_W-1:0] p_def;
  logic [ATK_W-1:0] ai_atk;
  logic [ATK_W-1:0] ai_def;
  logic [HP_W-1:0]  p_hp;
  logic [HP_W-1:0]  ai_hp;
  logic             busy;
  logic             done;
  logic             p_fainted;
  logic             ai_fainted;
  logic             req_err;

  modport master (
    output load_ai_hp, ai_hp_in, apply_p_damage, apply_ai_damage,
           active_trainer, target, p_atk, p_def, ai_atk, ai_def,
    input  p_hp, ai_hp, busy, done, p_fainted, ai_fainted, req_err
  );

  modport slave (
    input  load_ai_hp, ai_hp_in, apply_p_damage, apply_ai_damage,
           active_trainer, target, p_atk, p_def, ai_atk, ai_def,
    output p_hp, ai_hp, busy, done, p_fainted, ai_fainted, req_err
  );
endinterface

// File: rtl/hp_damage_unit.sv
// rtl/hp_damage_unit.sv - damage calculation and paced HP drain with faint and request-error status
module hp_damage_unit #(
  parameter int HP_W      = 8,
  parameter int ATK_W     = 4,
  parameter int MAX_HP    = 100,
  parameter int DRAIN_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  hp_damage_unit_if.slave      bus
);
  localparam int DIV_W = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
  localparam logic [HP_W-1:0]  HP_MAX   = HP_W'(MAX_HP);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DRAIN_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [HP_W-1:0]  p_hp_q, p_hp_d;
  logic [HP_W-1:0]  ai_hp_q, ai_hp_d;
  logic [HP_W-1:0]  rem_q, rem_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [ATK_W-1:0] atk_q, atk_d;
  logic [ATK_W-1:0] def_q, def_d;
  logic             tgt_q, tgt_d;
  logic             armed_q, armed_d;
  logic             req_err_q, req_err_d;
  logic             p_fainted_q, p_fainted_d;
  logic             ai_fainted_q, ai_fainted_d;

  logic [ATK_W-1:0] dmg;
  logic [HP_W-1:0]  dmg_ext;
  logic [HP_W-1:0]  tgt_hp;
  logic [HP_W-1:0]  load_val;

  assign dmg      = (atk_q > def_q) ? (atk_q - def_q) : ATK_W'(1);
  assign dmg_ext  = HP_W'(dmg);
  assign tgt_hp   = tgt_q ? ai_hp_q : p_hp_q;
  assign load_val = (bus.ai_hp_in > HP_MAX) ? HP_MAX : bus.ai_hp_in;

  always_comb begin
    state_d   = state_q;
    p_hp_d    = p_hp_q;
    ai_hp_d   = ai_hp_q;
    rem_d     = rem_q;
    div_d     = div_q;
    atk_d     = atk_q;
    def_d     = def_q;
    tgt_d     = tgt_q;
    armed_d   = armed_q;
    req_err_d = 1'b0;

    // Re-arm whenever upstream drops both request levels, in any state.
    if (!bus.apply_p_damage && !bus.apply_ai_damage) begin
      armed_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (armed_q && bus.apply_ai_damage) begin
          armed_d = 1'b0;
          if (bus.target && !bus.active_trainer) begin
            atk_d   = bus.p_atk;
            def_d   = bus.ai_def;
            tgt_d   = 1'b1;
            state_d = S_CALC;
          end else begin
            req_err_d = 1'b1;
          end
        end else if (armed_q && bus.apply_p_damage) begin
          armed_d = 1'b0;
          if (!bus.target && bus.active_trainer) begin
            atk_d   = bus.ai_atk;
            def_d   = bus.p_def;
            tgt_d   = 1'b0;
            state_d = S_CALC;
          end else begin
            req_err_d = 1'b1;
          end
        end else if (bus.load_ai_hp) begin
          ai_hp_d = load_val;
        end
      end
      S_CALC: begin
        // Clamping to current HP is what keeps the drain from wrapping below zero.
        rem_d   = (dmg_ext < tgt_hp) ? dmg_ext : tgt_hp;
        div_d   = '0;
        state_d = ((dmg_ext < tgt_hp ? dmg_ext : tgt_hp) == '0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          rem_d = rem_q - 1'b1;
          if (tgt_q) ai_hp_d = ai_hp_q - 1'b1;
          else       p_hp_d  = p_hp_q - 1'b1;
          if (rem_q == HP_W'(1)) state_d = S_DONE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    p_fainted_d  = (p_hp_d == '0);
    ai_fainted_d = (ai_hp_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      p_hp_q       <= HP_MAX;
      ai_hp_q      <= HP_MAX;
      rem_q        <= '0;
      div_q        <= '0;
      atk_q        <= '0;
      def_q        <= '0;
      tgt_q        <= 1'b0;
      armed_q      <= 1'b1;
      req_err_q    <= 1'b0;
      p_fainted_q  <= 1'b0;
      ai_fainted_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      p_hp_q       <= p_hp_d;
      ai_hp_q      <= ai_hp_d;
      rem_q        <= rem_d;
      div_q        <= div_d;
      atk_q        <= atk_d;
      def_q        <= def_d;
      tgt_q        <= tgt_d;
      armed_q      <= armed_d;
      req_err_q    <= req_err_d;
      p_fainted_q  <= p_fainted_d;
      ai_fainted_q <= ai_fainted_d;
    end
  end

  assign bus.p_hp       = p_hp_q;
  assign bus.ai_hp      = ai_hp_q;
  assign bus.busy       = (state_q == S_CALC) || (state_q == S_DRAIN);
  assign bus.done       = (state_q == S_DONE);
  assign bus.p_fainted  = p_fainted_q;
  assign bus.ai_fainted = ai_fainted_q;
  assign bus.req_err    = req_err_q;
endmodule
